row_mac_accumulate_8: RTL and testbench
=======================================

# row_mac_accumulate_8

Downstream of the 8-lane column-gather stage. Consumes one 8-element gathered vector chunk per valid cycle together with the 8 matching nonzero matrix values, multiplies lane-wise, reduces through an adder tree, and accumulates across the `no_of_multiples` chunks belonging to one sparse row. Emits one row dot-product per row with a single-cycle valid strobe, feeding the result write-back and solver-update logic.

## Interface
- `element_width`, 32: width of each vector and matrix element, signed two's complement.
- `no_of_elements_in_output`, 8: lanes per chunk; fixed at 8 for this block.
- `acc_width`, 72: accumulator and result width; must be at least 2*element_width+3.
- `multiples_memory_value_width`, 32: width of the chunk count.
- `row_index_width`, 16: width of the row counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `vector_row`  in  8*element_width  gathered vector chunk; lane 7 at the MSBs, matching gather `output_row` order.
- `matrix_row`  in  8*element_width  nonzero values aligned lane-for-lane with `vector_row`.
- `in_valid`  in  1  chunk valid; `vector_row` and `matrix_row` are sampled on the same edge.
- `no_of_multiples`  in  multiples_memory_value_width  chunk count for the current row.
- `row_result`  out  acc_width  completed row dot-product.
- `result_valid`  out  1  one-cycle strobe qualifying `row_result`.
- `row_index`  out  row_index_width  index of the row that `row_result` belongs to.
- `busy`  out  1  high while a row is partially accumulated.

## Operation
- Stage P1, on `in_valid`: register 8 signed products `vector_row[k]*matrix_row[k]`. Each product is full width, 2*element_width bits.
- Stage P2: a registered adder tree sums the 8 products, sign-extended to acc_width.
- Stage P3: the accumulator either loads the tree sum (first chunk of a row) or adds it to the running value. Arithmetic wraps modulo 2^acc_width; there is no saturation.
- Chunk counting and row boundaries:
  - `no_of_multiples` is latched on the first chunk of each row. Later changes within the row are ignored.
  - A latched value of 0 is treated as 1.
  - The chunk counter runs 1..N and returns to 1 after chunk N.
  - The first/last flags travel down the pipeline alongside the data.
- FSM:
  - IDLE: `busy`=0. On `in_valid` with N=1, stay in IDLE and mark the chunk first+last. With N>1, go to ACCUM and mark the chunk first.
  - ACCUM: `busy`=1. Each `in_valid` increments the counter. On chunk N, mark it last and return to IDLE.
- On a last chunk reaching P3:
  - `row_result` takes the final sum, `result_valid` pulses for one cycle, `row_index` takes the row counter.
  - The row counter increments after `row_index` is taken, and wraps at 2^row_index_width.
- Gaps: `in_valid` low cycles between chunks are allowed. The pipeline holds nothing; bubbles propagate and the accumulator is unchanged during them.
- Invalid gather lanes arrive as zero, so their products are zero and need no special handling.

## Timing
- Reset values: `row_result`=0, `result_valid`=0, `row_index`=0, `busy`=0. Accumulator, counters, pipeline valid bits and the FSM state are all cleared.
- Latency: `result_valid` asserts exactly 3 cycles after the edge that samples the last chunk's `in_valid`.
- Throughput: one chunk per cycle sustained, and back-to-back rows are supported. The first chunk of row r+1 may follow the last chunk of row r on the next cycle; its accumulator load is not polluted by row r.
- Consecutive N=1 rows give `result_valid` on consecutive cycles.
- `row_result` holds its value between strobes.
- Reset asserted mid-row or with chunks in flight discards the partial sum and all in-flight chunks. No `result_valid` is produced for them, and `row_index` restarts at 0.
- `busy` is a registered output of the FSM state. It does not account for the 3 cycles of pipeline drain.

## Structure
- Shared package `spmv_pkg`:
  - constants for default element_width, lane count 8, acc_width;
  - an FSM state enum {IDLE, ACCUM};
  - a typedef for the packed 8-lane row.
- Sub-module `adder_tree_8`: registered 8-input signed sum (P2), parameterised by input and output width. Multipliers, counter, FSM and accumulator stay in the top module.

## Test plan
- N=1, vector lanes all 2, matrix lanes 1..8 -> one `result_valid` 3 cycles later, `row_result`=72, `row_index`=0.
- N=3, three chunks with lane values 1*1 (sum 8), 2*3 (sum 48) and -1*5 (sum -40), with a 2-cycle `in_valid` gap before chunk 3 -> `row_result`=16, `busy` high from chunk 1 until chunk 3 is sampled.
- Back-to-back rows with N=2 then N=1, no gaps -> two strobes, `row_index` values 0 then 1, second result independent of the first.
- Extremes: lanes 0x80000000 * 0x80000000 in all 8 lanes, N=1 -> `row_result`=8*2^62 with no overflow in a 72-bit accumulator. Zero lanes produce 0.
- `rst` asserted after chunk 2 of an N=4 row -> no `result_valid`. All outputs are 0 the cycle after reset, and the next N=1 row gets `row_index`=0.
- `no_of_multiples`=0 -> behaves as N=1. Changing `no_of_multiples` mid-row does not alter that row's chunk count.

Source files
------------

// File: rtl/spmv_pkg.sv
// spmv_pkg: shared widths, FSM states and lane helpers for the sparse row MAC.
package spmv_pkg;
    localparam int element_width = 32;
    localparam int no_of_elements_in_output = 8;
    localparam int acc_width = 72;
    localparam int multiples_memory_value_width = 32;
    localparam int row_index_width = 16;
    typedef enum logic {IDLE, ACCUM} state_t;
    typedef logic [no_of_elements_in_output*element_width-1:0] row_t;
    typedef logic signed [2*element_width-1:0] prod_t;
    function automatic prod_t lane_mul(logic [element_width-1:0] a, logic [element_width-1:0] b);
        return prod_t'(signed'(a)) * prod_t'(signed'(b));
    endfunction
endpackage

// File: rtl/row_mac_accumulate_8_if.sv
// row_mac_accumulate_8_if: chunk input and row result bus of the row MAC.
interface row_mac_accumulate_8_if;
    import spmv_pkg::*;
    row_t vector_row;
    row_t matrix_row;
    logic in_valid;
    logic [multiples_memory_value_width-1:0] no_of_multiples;
    logic [acc_width-1:0] row_result;
    logic result_valid;
    logic [row_index_width-1:0] row_index;
    logic busy;
    modport master (
        output vector_row, matrix_row, in_valid, no_of_multiples,
        input  row_result, result_valid, row_index, busy
    );
    modport slave (
        input  vector_row, matrix_row, in_valid, no_of_multiples,
        output row_result, result_valid, row_index, busy
    );
endinterface

// File: rtl/adder_tree_8.sv
// adder_tree_8: registered signed sum of 8 terms, sign-extended to the output width.
module adder_tree_8 #(
    parameter int in_width = 64,
    parameter int out_width = 72
) (
    input  logic clk,
    input  logic rst,
    input  logic signed [in_width-1:0] terms [8],
    output logic signed [out_width-1:0] sum
);
    logic signed [out_width-1:0] l1 [4];
    logic signed [out_width-1:0] l2 [2];
    always_comb begin
        for (int k = 0; k < 4; k++)
            l1[k] = out_width'(terms[2*k]) + out_width'(terms[2*k+1]);
        for (int k = 0; k < 2; k++)
            l2[k] = l1[2*k] + l1[2*k+1];
    end
    always_ff @(posedge clk)
        sum <= rst ? '0 : l2[0] + l2[1];
endmodule

// File: rtl/row_mac_accumulate_8.sv
// row_mac_accumulate_8: lane-wise multiply, tree reduce and accumulate chunks into one dot-product per row.
module row_mac_accumulate_8
    import spmv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    row_mac_accumulate_8_if.slave bus
);
    localparam int mw = multiples_memory_value_width;
    state_t state, state_next;
    logic [mw-1:0] cnt, n_lat, n_eff, cnt_now, lim;
    logic first, last;
    prod_t prod [no_of_elements_in_output];
    prod_t p1_prod [no_of_elements_in_output];
    logic p1_valid, p1_first, p1_last, p2_valid, p2_first, p2_last;
    logic signed [acc_width-1:0] tree_sum, acc, acc_next;
    logic [row_index_width-1:0] row_ctr;
    always_comb begin
        n_eff = bus.no_of_multiples == '0 ? mw'(1) : bus.no_of_multiples;
        first = state == IDLE;
        lim = first ? n_eff : n_lat;
        cnt_now = first ? mw'(1) : cnt + mw'(1);
        last = cnt_now == lim;
        state_next = !bus.in_valid ? state : last ? IDLE : ACCUM;
        for (int k = 0; k < no_of_elements_in_output; k++)
            prod[k] = lane_mul(bus.vector_row[k*element_width +: element_width],
                               bus.matrix_row[k*element_width +: element_width]);
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;
    // the row length is frozen on the first chunk so mid-row changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            n_lat <= '0;
        end else if (bus.in_valid) begin
            cnt <= cnt_now;
            if (first) n_lat <= n_eff;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {p1_valid, p1_first, p1_last} <= '0;
            {p2_valid, p2_first, p2_last} <= '0;
        end else begin
            p1_valid <= bus.in_valid;
            p1_first <= first;
            p1_last <= last;
            p2_valid <= p1_valid;
            p2_first <= p1_first;
            p2_last <= p1_last;
        end
        if (bus.in_valid) p1_prod <= prod;
    end
    adder_tree_8 #(.in_width(2*element_width), .out_width(acc_width)) u_tree (
        .clk(clk),
        .rst(rst),
        .terms(p1_prod),
        .sum(tree_sum)
    );
    assign acc_next = p2_first ? tree_sum : acc + tree_sum;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            row_ctr <= '0;
            bus.row_result <= '0;
            bus.result_valid <= 1'b0;
            bus.row_index <= '0;
        end else begin
            bus.result_valid <= p2_valid && p2_last;
            if (p2_valid) acc <= acc_next;
            if (p2_valid && p2_last) begin
                bus.row_result <= acc_next;
                bus.row_index <= row_ctr;
                row_ctr <= row_ctr + row_index_width'(1);
            end
        end
    end
    assign bus.busy = state == ACCUM;
endmodule

// File: tb/tb_row_mac_accumulate_8.sv
// tb_row_mac_accumulate_8: directed and random chunks against a row-level dot-product model.
module tb_row_mac_accumulate_8;
    import spmv_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    row_mac_accumulate_8_if bus();
    row_mac_accumulate_8 dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int due;
        logic [71:0] sum;
        logic [15:0] idx;
    } exp_t;
    exp_t expq[$];
    int cyc = 0;
    int passed = 0;
    int total = 0;
    logic in_row = 1'b0;
    longint left = 0;
    logic signed [71:0] run = '0;
    logic [15:0] row_ctr = '0;
    logic [71:0] held = '0;
    logic [15:0] held_idx = '0;
    logic exp_valid = 1'b0;

    // Row-level model: each completed row is due on the third edge counting its last chunk's sampling edge.
    always @(posedge clk) begin
        logic signed [71:0] s;
        logic signed [31:0] a, b;
        longint n;
        cyc++;
        exp_valid = 1'b0;
        if (rst) begin
            expq.delete();
            in_row = 1'b0;
            left = 0;
            run = '0;
            row_ctr = '0;
            held = '0;
            held_idx = '0;
        end else begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                held = expq[0].sum;
                held_idx = expq[0].idx;
                exp_valid = 1'b1;
                void'(expq.pop_front());
            end
            if (bus.in_valid) begin
                s = '0;
                for (int k = 0; k < 8; k++) begin
                    a = bus.vector_row[k*32 +: 32];
                    b = bus.matrix_row[k*32 +: 32];
                    s += 72'(longint'(a) * longint'(b));
                end
                if (!in_row) begin
                    n = longint'(bus.no_of_multiples);
                    left = n == 0 ? 1 : n;
                    run = s;
                end else begin
                    run += s;
                end
                left--;
                in_row = left != 0;
                if (!in_row) begin
                    expq.push_back('{cyc + 2, run, row_ctr});
                    row_ctr++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic row_t lanes(input logic [31:0] base, input logic [31:0] step);
        row_t r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + step * k;
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: r[k*32 +: 32] = '0;
                1: r[k*32 +: 32] = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7fff_ffff;
                default: r[k*32 +: 32] = $urandom;
            endcase
        end
        return r;
    endfunction

    task automatic chunk(input row_t v, input row_t m, input logic [31:0] nom);
        @(negedge clk);
        bus.vector_row = v;
        bus.matrix_row = m;
        bus.no_of_multiples = nom;
        bus.in_valid = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic expect_row(input logic [71:0] r, input logic [15:0] idx, input int lat, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            n++;
        end while (!bus.result_valid && n < 8);
        check({name, " strobe latency"}, 72'(n), 72'(lat));
        check({name, " row_result"}, bus.row_result, r);
        check({name, " row_index"}, 72'(bus.row_index), 72'(idx));
    endtask

    initial begin
        bus.vector_row = '0;
        bus.matrix_row = '0;
        bus.no_of_multiples = '0;
        bus.in_valid = 1'b0;
        fork
            forever begin
                @(negedge clk);
                check("result_valid", 72'(bus.result_valid), 72'(exp_valid));
                check("row_result", bus.row_result, held);
                check("row_index", 72'(bus.row_index), 72'(held_idx));
                check("busy", 72'(bus.busy), 72'(in_row));
            end
        join_none
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset row_result", bus.row_result, 72'd0);
        check("reset result_valid", 72'(bus.result_valid), 72'd0);
        check("reset row_index", 72'(bus.row_index), 72'd0);
        check("reset busy", 72'(bus.busy), 72'd0);

        chunk(lanes(2, 0), lanes(1, 1), 1);
        expect_row(72'd72, 16'd0, 3, "n1 row");

        chunk(lanes(1, 0), lanes(1, 0), 3);
        chunk(lanes(2, 0), lanes(3, 0), 3);
        gap(2);
        check("busy mid-row", 72'(bus.busy), 72'd1);
        chunk(lanes(32'hffff_ffff, 0), lanes(5, 0), 3);
        expect_row(72'd16, 16'd1, 3, "n3 row");
        check("busy after row", 72'(bus.busy), 72'd0);

        chunk(lanes(1, 0), lanes(1, 1), 2);
        chunk(lanes(1, 0), lanes(1, 0), 7);
        chunk(lanes(1, 1), lanes(3, 0), 1);
        expect_row(72'd44, 16'd2, 2, "b2b first");
        expect_row(72'd108, 16'd3, 1, "b2b second");

        chunk(lanes(32'h8000_0000, 0), lanes(32'h8000_0000, 0), 1);
        expect_row(72'h2_0000_0000_0000_0000, 16'd4, 3, "extreme");
        chunk(lanes(0, 0), rand_row(), 1);
        expect_row(72'd0, 16'd5, 3, "zero lanes");

        chunk(lanes(1, 0), lanes(1, 0), 4);
        chunk(lanes(1, 0), lanes(1, 0), 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post-reset row_result", bus.row_result, 72'd0);
        check("post-reset result_valid", 72'(bus.result_valid), 72'd0);
        check("post-reset row_index", 72'(bus.row_index), 72'd0);
        check("post-reset busy", 72'(bus.busy), 72'd0);
        gap(6);
        chunk(lanes(1, 0), lanes(1, 0), 1);
        expect_row(72'd8, 16'd0, 3, "after reset");

        chunk(lanes(1, 0), lanes(2, 0), 0);
        expect_row(72'd16, 16'd1, 3, "n0 row");
        chunk(lanes(1, 0), lanes(1, 0), 3);
        chunk(lanes(1, 0), lanes(1, 0), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("busy ignores new count", 72'(bus.busy), 72'd1);
        chunk(lanes(1, 0), lanes(1, 0), 0);
        expect_row(72'd24, 16'd2, 3, "latched count");

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.in_valid = $urandom_range(0, 9) < 7;
            bus.vector_row = rand_row();
            bus.matrix_row = rand_row();
            bus.no_of_multiples = $urandom_range(0, 4);
        end
        gap(8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
